qpu_dtcm_mport_ctrl: RTL and testbench
======================================

QPU_DTCM_MPORT_CTRL -- requirements
Module: QPU_dtcm_mport_ctrl

Interface
REQ-001 SHALL have parameters: NP default 2, number of ICB ports; DW default 32, data width; AW default 16, byte address width; DEPTH default 4096, SRAM words; RAW default 12, SRAM word-address width (log2 DEPTH).
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock
  rst_n  in  1  async active-low reset
  tcm_cgstop  in  1  disable RAM clock gating
  test_mode  in  1  force RAM clock on
  i_icb_cmd_valid  in  NP  per-port cmd valid
  i_icb_cmd_ready  out  NP  per-port cmd ready
  i_icb_cmd_read  in  NP  1=read, 0=write
  i_icb_cmd_addr  in  NP*AW  byte addresses, port p at [p*AW +: AW]
  i_icb_cmd_wdata  in  NP*DW  write data
  i_icb_cmd_wmask  in  NP*(DW/8)  byte enables
  i_icb_rsp_valid  out  NP  per-port rsp valid
  i_icb_rsp_ready  in  NP  per-port rsp ready
  i_icb_rsp_rdata  out  DW  shared rsp data, valid with the asserted rsp_valid bit
  i_icb_rsp_err  out  1  rsp error flag
  ram_cs  out  1  SRAM select
  ram_we  out  1  SRAM write
  ram_addr  out  RAW  SRAM word address
  ram_wem  out  DW/8  SRAM byte write enables
  ram_din  out  DW  SRAM write data
  ram_dout  in  DW  SRAM read data, 1-cycle latency, held until next cs
  clk_ram  out  1  gated SRAM clock
  ctrl_active  out  1  cmd pending or rsp outstanding

Function
REQ-003 SHALL grant at most one port per cycle, round-robin: priority starts after the last granted port; after reset port 0 has highest priority.
REQ-004 SHALL assert i_icb_cmd_ready[p] only for the granted port, and only when no response is outstanding or the outstanding response handshakes in the same cycle.
REQ-005 SHALL drive the SRAM in the accept cycle: ram_cs=1, ram_we=~read, ram_addr=addr[AW_LSB+RAW-1:AW_LSB] with AW_LSB=log2(DW/8), ram_wem=wmask when writing else 0, ram_din=wdata.
REQ-006 SHALL assert i_icb_rsp_valid[owner] the cycle after acceptance and hold it, with rdata/err stable, until rsp_ready[owner]=1.
REQ-007 SHALL return rdata=ram_dout for reads and rdata=0 for writes.
REQ-008 SHALL treat word address >= DEPTH as an error: no ram_cs, rsp_err=1, rdata=0, same 1-cycle response timing.
REQ-009 SHALL keep ram_cs=0 while a response is stalled, so ram_dout is preserved.
REQ-010 SHALL sustain one access per cycle when rsp_ready is held high (back-to-back, including across ports).
REQ-011 SHALL accept a new command in the cycle the outstanding response completes (rsp handshake and cmd handshake together).
REQ-012 SHALL run clk_ram only in cycles with ram_cs=1, or always when tcm_cgstop=1 or test_mode=1, using a glitch-free latch-based gate.
REQ-013 SHALL drive ctrl_active=|i_icb_cmd_valid | rsp outstanding.
REQ-014 SHALL ignore the valid bits of non-granted ports; those requests stay pending with no loss.

Reset
REQ-015 SHALL, on rst_n=0, clear asynchronously: rsp_valid=0, rsp_err=0, outstanding=0, and round-robin pointer to port 0.
REQ-016 SHALL abandon any outstanding response when reset asserts mid-transaction and leave no SRAM write partially issued after release (ram_cs=0 during reset).

Structure
REQ-017 SHALL take AW_LSB, the default widths and the DEPTH constants from QPU_defines.v (QPU_DTCM_*).
REQ-018 SHALL instantiate one sub-module, QPU_rr_arb (NP requests -> one-hot grant, pointer advanced on handshake), plus the shared clock-gate cell.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
  - Write port0 addr 0x10 wdata 0xDEADBEEF wmask 0xF, then read 0x10 -> rdata 0xDEADBEEF, err 0, rsp 1 cycle after accept.
  - Write wmask 0x2 wdata 0x0000AA00 over 0xDEADBEEF -> readback 0xDEADAABE... corrected: 0xDEADAAEF.
  - Both ports valid for 4 cycles, rsp_ready=1 -> grants 0,1,0,1, one accept per cycle.
  - Port0 rsp_ready=0 for 3 cycles -> rsp_valid/rdata held, cmd_ready=0, ram_cs=0, port1 stalled; accept on release cycle.
  - Read addr DEPTH*4 -> err 1, rdata 0, ram_cs never asserted.
  - rst_n low while rsp outstanding -> rsp_valid 0 immediately; first post-reset grant is port 0.

Source files
------------

// File: rtl/qpu_dtcm_mport_ctrl_pkg.sv
// qpu_dtcm_mport_ctrl_pkg: shared DTCM port-controller constants and helpers
package qpu_dtcm_mport_ctrl_pkg;
  localparam int QPU_DTCM_NP = 2;
  localparam int QPU_DTCM_DW = 32;
  localparam int QPU_DTCM_AW = 16;
  localparam int QPU_DTCM_DEPTH = 4096;
  localparam int QPU_DTCM_RAW = 12;
  function automatic int aw_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/qpu_dtcm_mport_ctrl_arb.sv
// qpu_dtcm_mport_ctrl_arb: round-robin one-hot arbiter, pointer moves past the winner on handshake
module qpu_dtcm_mport_ctrl_arb #(
  parameter int NP = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NP-1:0] req_i,
  input  logic          hs_i,
  output logic [NP-1:0] gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] prio_q, prio_d, k;
  // scan from the farthest port back to the pointer so the closest requester wins
  always_comb begin
    idx_o = '0;
    k = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      k = IW'((int'(prio_q) + i) % NP);
      if (req_i[k]) idx_o = k;
    end
    gnt_o = |req_i ? NP'(1) << idx_o : '0;
    prio_d = hs_i ? IW'((int'(idx_o) + 1) % NP) : prio_q;
  end
  // priority pointer, port 0 first after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio_q <= '0;
    else prio_q <= prio_d;
endmodule

// File: rtl/qpu_dtcm_mport_ctrl.sv
// qpu_dtcm_mport_ctrl: multi-port ICB front end for a single-port DTCM SRAM with gated RAM clock
module qpu_dtcm_mport_ctrl
  import qpu_dtcm_mport_ctrl_pkg::*;
#(
  parameter int NP = QPU_DTCM_NP,
  parameter int DW = QPU_DTCM_DW,
  parameter int AW = QPU_DTCM_AW,
  parameter int DEPTH = QPU_DTCM_DEPTH,
  parameter int RAW = QPU_DTCM_RAW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tcm_cgstop,
  input  logic               test_mode,
  input  logic [NP-1:0]      i_icb_cmd_valid,
  output logic [NP-1:0]      i_icb_cmd_ready,
  input  logic [NP-1:0]      i_icb_cmd_read,
  input  logic [NP*AW-1:0]   i_icb_cmd_addr,
  input  logic [NP*DW-1:0]   i_icb_cmd_wdata,
  input  logic [NP*DW/8-1:0] i_icb_cmd_wmask,
  output logic [NP-1:0]      i_icb_rsp_valid,
  input  logic [NP-1:0]      i_icb_rsp_ready,
  output logic [DW-1:0]      i_icb_rsp_rdata,
  output logic               i_icb_rsp_err,
  output logic               ram_cs,
  output logic               ram_we,
  output logic [RAW-1:0]     ram_addr,
  output logic [DW/8-1:0]    ram_wem,
  output logic [DW-1:0]      ram_din,
  input  logic [DW-1:0]      ram_dout,
  output logic               clk_ram,
  output logic               ctrl_active
);
  localparam int MW = DW / 8;
  localparam int AW_LSB = aw_lsb(DW);
  localparam int IW = NP > 1 ? $clog2(NP) : 1;
  logic [NP-1:0] gnt, owner_q, owner_d;
  logic [IW-1:0] gidx;
  logic [AW-1:0] sel_addr;
  logic outstanding_q, outstanding_d, err_q, err_d, rd_q, rd_d;
  logic rsp_hs, can_accept, accept, oob, sel_read, clk_en, clk_en_lat;
  qpu_dtcm_mport_ctrl_arb #(.NP(NP), .IW(IW)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (i_icb_cmd_valid),
    .hs_i  (accept),
    .gnt_o (gnt),
    .idx_o (gidx)
  );
  assign sel_addr = i_icb_cmd_addr[gidx*AW +: AW];
  assign sel_read = i_icb_cmd_read[gidx];
  assign oob = (32'(sel_addr) >> AW_LSB) >= 32'(DEPTH);
  assign rsp_hs = outstanding_q & |(owner_q & i_icb_rsp_ready);
  assign can_accept = rst_n & (~outstanding_q | rsp_hs);
  assign i_icb_cmd_ready = gnt & {NP{can_accept}};
  assign accept = can_accept & |gnt;
  assign ram_cs = accept & ~oob;
  assign ram_we = ram_cs & ~sel_read;
  assign ram_addr = sel_addr[AW_LSB +: RAW];
  assign ram_wem = ram_we ? i_icb_cmd_wmask[gidx*MW +: MW] : '0;
  assign ram_din = i_icb_cmd_wdata[gidx*DW +: DW];
  assign i_icb_rsp_valid = owner_q & {NP{outstanding_q}};
  assign i_icb_rsp_err = outstanding_q & err_q;
  assign i_icb_rsp_rdata = (outstanding_q & rd_q & ~err_q) ? ram_dout : '0;
  assign ctrl_active = |i_icb_cmd_valid | outstanding_q;
  // a new accept replaces the response slot; otherwise it empties on handshake
  always_comb begin
    outstanding_d = accept | (outstanding_q & ~rsp_hs);
    owner_d = accept ? gnt : owner_q;
    err_d = accept ? oob : err_q;
    rd_d = accept ? sel_read : rd_q;
  end
  // response slot registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      outstanding_q <= 1'b0;
      owner_q <= '0;
      err_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      owner_q <= owner_d;
      err_q <= err_d;
      rd_q <= rd_d;
    end
  assign clk_en = ram_cs | tcm_cgstop | test_mode;
  // enable latch is transparent only while clk is low so the gated clock cannot glitch
  always_latch
    if (!clk) clk_en_lat <= clk_en;
  assign clk_ram = clk & clk_en_lat;
endmodule

// File: tb/tb_qpu_dtcm_mport_ctrl.sv
// tb_qpu_dtcm_mport_ctrl: randomized + directed bench against a transaction-level reference model
module tb_qpu_dtcm_mport_ctrl;
  localparam int NP = 2, DW = 32, AW = 16, DEPTH = 4096, RAW = 12, MW = 4;
  logic clk = 1'b0, rst_n = 1'b0, tcm_cgstop = 1'b0, test_mode = 1'b0;
  logic [NP-1:0] cmd_valid = '0, cmd_ready, cmd_read = '0, rsp_valid, rsp_ready = '0;
  logic [NP*AW-1:0] cmd_addr = '0;
  logic [NP*DW-1:0] cmd_wdata = '0;
  logic [NP*MW-1:0] cmd_wmask = '0;
  logic [DW-1:0] rsp_rdata, ram_din, ram_dout;
  logic rsp_err, ram_cs, ram_we, clk_ram, ctrl_active;
  logic [RAW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [NP-1:0] c_v = '0;
  logic c_rd [NP];
  logic [AW-1:0] c_addr [NP];
  logic [DW-1:0] c_wd [NP];
  logic [MW-1:0] c_wm [NP];
  bit has_rsp, m_err;
  int ptr, m_owner, acc_port;
  logic [DW-1:0] m_rdata, last_rdata;
  logic last_err;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  qpu_dtcm_mport_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tcm_cgstop(tcm_cgstop), .test_mode(test_mode),
    .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready), .i_icb_cmd_read(cmd_read),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready), .i_icb_rsp_rdata(rsp_rdata),
    .i_icb_rsp_err(rsp_err), .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout), .clk_ram(clk_ram),
    .ctrl_active(ctrl_active)
  );
  always @(posedge clk)
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++) if (ram_wem[b]) sram[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end else ram_dout <= sram[ram_addr];
    end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      cmd_read[p] = c_rd[p];
      cmd_addr[p*AW +: AW] = c_addr[p];
      cmd_wdata[p*DW +: DW] = c_wd[p];
      cmd_wmask[p*MW +: MW] = c_wm[p];
    end
    cmd_valid = c_v;
  endtask
  task automatic set_cmd(input int p, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    c_v[p] = 1'b1;
    c_rd[p] = rd;
    c_addr[p] = a;
    c_wd[p] = wd;
    c_wm[p] = wm;
  endtask
  task automatic new_cmd(input int p);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 7) == 0) ? AW'(($urandom_range(DEPTH, 16383) << 2) | $urandom_range(0, 3))
                                    : AW'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
    set_cmd(p, 1'($urandom_range(0, 1)), a, $urandom, MW'($urandom_range(0, 15)));
  endtask
  task automatic model_reset();
    has_rsp = 0;
    ptr = 0;
  endtask
  task automatic step();
    int win, acc;
    bit hs, free, oob, cs;
    logic [NP-1:0] e_ready, e_rv;
    logic [AW-3:0] word;
    drive();
    e_rv = has_rsp ? NP'(1) << m_owner : '0;
    hs = has_rsp && rsp_ready[m_owner];
    free = !has_rsp || hs;
    win = -1;
    for (int i = NP - 1; i >= 0; i--) if (c_v[(ptr + i) % NP]) win = (ptr + i) % NP;
    acc = free ? win : -1;
    e_ready = acc >= 0 ? NP'(1) << acc : '0;
    oob = acc >= 0 && (c_addr[acc] >> 2) >= DEPTH;
    cs = acc >= 0 && !oob;
    #3;
    chk("cmd_ready", cmd_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("ctrl_active", ctrl_active, |c_v | has_rsp);
    chk("ram_cs", ram_cs, cs);
    if (has_rsp) begin
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      last_rdata = rsp_rdata;
      last_err = rsp_err;
    end
    if (cs) begin
      chk("ram_we", ram_we, !c_rd[acc]);
      chk("ram_addr", ram_addr, c_addr[acc][RAW+1:2]);
      chk("ram_wem", ram_wem, c_rd[acc] ? '0 : c_wm[acc]);
      chk("ram_din", ram_din, c_wd[acc]);
    end
    @(posedge clk);
    #1;
    chk("clk_ram", clk_ram, cs | tcm_cgstop | test_mode);
    acc_port = acc;
    if (acc >= 0) begin
      word = c_addr[acc][AW-1:2];
      ptr = (acc + 1) % NP;
      has_rsp = 1;
      m_owner = acc;
      m_err = oob;
      m_rdata = '0;
      if (!oob && c_rd[acc]) m_rdata = ref_mem[word[RAW-1:0]];
      if (!oob && !c_rd[acc])
        for (int b = 0; b < MW; b++) if (c_wm[acc][b]) ref_mem[word[RAW-1:0]][b*8 +: 8] = c_wd[acc][b*8 +: 8];
      c_v[acc] = 1'b0;
    end else if (hs) has_rsp = 0;
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    ram_dout = '0;
    for (int p = 0; p < NP; p++) set_cmd(p, 1'b1, '0, '0, '0);
    c_v = '0;
    drive();
    model_reset();
    #12;
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ctrl_active", ctrl_active, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = '1;
    set_cmd(0, 1'b0, 16'h0010, 32'hDEADBEEF, 4'hF);
    step();
    set_cmd(0, 1'b1, 16'h0010, '0, '0);
    step();
    step();
    chk("rd_beef", last_rdata, 32'hDEADBEEF);
    chk("rd_beef_err", last_err, 0);
    set_cmd(0, 1'b0, 16'h0010, 32'h0000AA00, 4'h2);
    step();
    set_cmd(0, 1'b1, 16'h0010, '0, '0);
    step();
    step();
    chk("rd_mask", last_rdata, 32'hDEADAAEF);
    set_cmd(1, 1'b0, 16'h0020, 32'h12345678, 4'hF);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      set_cmd(0, 1'b1, 16'h0010, '0, '0);
      set_cmd(1, 1'b1, 16'h0020, '0, '0);
      step();
      chk("rr_gnt", acc_port, i % 2);
    end
    c_v = '0;
    step();
    set_cmd(0, 1'b1, 16'h0010, '0, '0);
    rsp_ready = 2'b10;
    step();
    set_cmd(1, 1'b1, 16'h0020, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rdata", last_rdata, 32'hDEADAAEF);
      chk("stall_no_acc", acc_port, -1);
    end
    rsp_ready = '1;
    step();
    chk("stall_release", acc_port, 1);
    step();
    chk("rd_20", last_rdata, 32'h12345678);
    set_cmd(0, 1'b1, 16'(DEPTH * 4), '0, '0);
    step();
    step();
    chk("oob_err", last_err, 1);
    chk("oob_rdata", last_rdata, 0);
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < NP; p++) if (!c_v[p] && $urandom_range(0, 1) == 1) new_cmd(p);
      rsp_ready = NP'($urandom_range(0, 3));
      tcm_cgstop = ($urandom_range(0, 15) == 0);
      test_mode = ($urandom_range(0, 15) == 0);
      step();
    end
    tcm_cgstop = 1'b0;
    test_mode = 1'b0;
    c_v = '0;
    rsp_ready = '1;
    step();
    step();
    set_cmd(0, 1'b1, 16'h0010, '0, '0);
    rsp_ready = '0;
    step();
    set_cmd(0, 1'b0, 16'h0030, 32'hCAFEF00D, 4'hF);
    set_cmd(1, 1'b0, 16'h0034, 32'h0BADBEEF, 4'hF);
    drive();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", rsp_valid, '0);
    chk("rst_mid_ram_cs", ram_cs, 0);
    chk("rst_mid_cmd_ready", cmd_ready, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = '1;
    step();
    chk("rst_first_gnt", acc_port, 0);
    step();
    c_v = '0;
    step();
    set_cmd(0, 1'b1, 16'h0030, '0, '0);
    step();
    step();
    chk("rst_wr_rd", last_rdata, 32'hCAFEF00D);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
